// File: rtl/squeeze_feeder_if.sv
// Bundled control, memory-read and MAC-bus signals of the squeeze operand feeder.
`timescale 1ns/1ps
interface squeeze_feeder_if #(
  parameter int INPUT_MULTIPLICAND = 16,
  parameter int PADDR_W            = 14,
  parameter int KADDR_W            = 6
);
  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          pix_rd_en;
  logic [PADDR_W-1:0]            pix_addr;
  logic [INPUT_MULTIPLICAND-1:0] pix_rdata;
  logic                          ker_rd_en;
  logic [KADDR_W-1:0]            ker_addr;
  logic [INPUT_MULTIPLICAND-1:0] ker_rdata;
  logic                          mac_rst;
  logic                          stop;
  logic [INPUT_MULTIPLICAND-1:0] pixel_in;
  logic [INPUT_MULTIPLICAND-1:0] kernel_in;
  logic                          result_valid;
  logic                          result_ready;

  modport master (
    input  start, pix_rdata, ker_rdata, result_ready,
    output busy, done, pix_rd_en, pix_addr, ker_rd_en, ker_addr,
           mac_rst, stop, pixel_in, kernel_in, result_valid
  );

  modport slave (
    output start, pix_rdata, ker_rdata, result_ready,
    input  busy, done, pix_rd_en, pix_addr, ker_rd_en, ker_addr,
           mac_rst, stop, pixel_in, kernel_in, result_valid
  );
endinterface

// File: rtl/squeeze_feeder.sv
// Operand sequencer for the squeeze MAC array: streams pixel/kernel pairs per
// output position, clears/gates the accumulators and flags final results.
`timescale 1ns/1ps
module squeeze_feeder #(
  parameter int INPUT_MULTIPLICAND = 16,
  parameter int CHANNELS           = 64,
  parameter int PIXELS             = 196,
  parameter int PADDR_W            = 14,
  parameter int KADDR_W            = 6,
  parameter int MAC_LAT            = 1
) (
  input  logic             clk,
  input  logic             rst,
  squeeze_feeder_if.master bus
);
  localparam int PIX_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int DRAIN_CYC = 2 + MAC_LAT;
  localparam int DRN_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [KADDR_W-1:0] LAST_CH  = KADDR_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0]   LAST_PIX = PIX_W'(PIXELS - 1);
  localparam logic [DRN_W-1:0]   LAST_DRN = DRN_W'(DRAIN_CYC - 1);
  localparam logic [INPUT_MULTIPLICAND-1:0] NO_OPERAND = '0;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESULT} state_t;

  state_t                        state;
  logic [PIX_W-1:0]              pix;
  logic [DRN_W-1:0]              drain_cnt;
  logic [PADDR_W-1:0]            pix_addr;
  logic [KADDR_W-1:0]            ch;
  logic                          rd_q;
  logic [INPUT_MULTIPLICAND-1:0] pixel_q;
  logic [INPUT_MULTIPLICAND-1:0] kernel_q;

  assign bus.pix_addr  = pix_addr;
  assign bus.ker_addr  = ch;
  assign bus.pixel_in  = pixel_q;
  assign bus.kernel_in = kernel_q;

  // Pixel addresses are contiguous across positions, so the running address
  // only ever increments; it restarts at 0 when a new run begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pix              <= '0;
      drain_cnt        <= '0;
      pix_addr         <= '0;
      ch               <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pix_rd_en    <= 1'b0;
      bus.ker_rd_en    <= 1'b0;
      bus.mac_rst      <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.mac_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.done) begin
            state       <= CLEAR;
            pix         <= '0;
            bus.busy    <= 1'b1;
            bus.mac_rst <= 1'b1;
          end
        end
        CLEAR: begin
          state         <= FEED;
          ch            <= '0;
          pix_addr      <= (pix == '0) ? '0 : pix_addr + 1'b1;
          bus.pix_rd_en <= 1'b1;
          bus.ker_rd_en <= 1'b1;
        end
        FEED: begin
          if (ch == LAST_CH) begin
            state         <= DRAIN;
            drain_cnt     <= '0;
            bus.pix_rd_en <= 1'b0;
            bus.ker_rd_en <= 1'b0;
          end else begin
            ch       <= ch + 1'b1;
            pix_addr <= pix_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRN) begin
            state            <= RESULT;
            bus.result_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            if (pix == LAST_PIX) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state       <= CLEAR;
              pix         <= pix + 1'b1;
              bus.mac_rst <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe; the delayed strobe marks
  // the cycle a valid pair is registered onto the bus and the MACs may add.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= 1'b0;
      bus.stop <= 1'b1;
      pixel_q  <= NO_OPERAND;
      kernel_q <= NO_OPERAND;
    end else begin
      rd_q     <= bus.pix_rd_en;
      bus.stop <= !rd_q;
      pixel_q  <= rd_q ? bus.pix_rdata : NO_OPERAND;
      kernel_q <= rd_q ? bus.ker_rdata : NO_OPERAND;
    end
  end
endmodule

// File: tb/tb_squeeze_feeder.sv
// Scoreboard bench for squeeze_feeder: two instances (4x2 and 1x3) with
// memory and MAC-array models; monitors pop expected reads/results.
`timescale 1ns/1ps
module tb_squeeze_feeder;
  localparam int IM  = 16;
  localparam int CA  = 4;
  localparam int PA  = 2;
  localparam int PWA = 3;
  localparam int KWA = 2;
  localparam int CB  = 1;
  localparam int PB  = 3;
  localparam int PWB = 2;
  localparam int KWB = 1;

  typedef struct { int addr; int ch; } rd_t;
  typedef struct { longint sum; bit last; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  squeeze_feeder_if #(.INPUT_MULTIPLICAND(IM), .PADDR_W(PWA), .KADDR_W(KWA)) bus_a ();
  squeeze_feeder_if #(.INPUT_MULTIPLICAND(IM), .PADDR_W(PWB), .KADDR_W(KWB)) bus_b ();

  squeeze_feeder #(.INPUT_MULTIPLICAND(IM), .CHANNELS(CA), .PIXELS(PA),
                   .PADDR_W(PWA), .KADDR_W(KWA), .MAC_LAT(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  squeeze_feeder #(.INPUT_MULTIPLICAND(IM), .CHANNELS(CB), .PIXELS(PB),
                   .PADDR_W(PWB), .KADDR_W(KWB), .MAC_LAT(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  rd_t  exp_rd_a[$];
  rd_t  exp_rd_b[$];
  res_t exp_res_a[$];
  res_t exp_res_b[$];
  rd_t  e_a, e_b;
  res_t r_a, r_b;
  int   done_a = 0, done_b = 0;
  int   run_a = 0, run_b = 0;
  bit   pend_done_a = 0;
  bit   prev_mrst_a = 0;
  logic [39:0] acc_a, acc_b;

  // Memory contents: pixel[a] = a+1, kernel[k] = k+2.
  always @(posedge clk) begin
    if (bus_a.pix_rd_en) bus_a.pix_rdata <= IM'(bus_a.pix_addr) + 16'd1;
    if (bus_a.ker_rd_en) bus_a.ker_rdata <= IM'(bus_a.ker_addr) + 16'd2;
    if (bus_b.pix_rd_en) bus_b.pix_rdata <= IM'(bus_b.pix_addr) + 16'd1;
    if (bus_b.ker_rd_en) bus_b.ker_rdata <= IM'(bus_b.ker_addr) + 16'd2;
  end

  // MAC array with one cycle of latency from bus operand to mac_out.
  always @(posedge clk) begin
    if (rst || bus_a.mac_rst) acc_a <= '0;
    else if (!bus_a.stop)     acc_a <= acc_a + bus_a.pixel_in * bus_a.kernel_in;
    if (rst || bus_b.mac_rst) acc_b <= '0;
    else if (!bus_b.stop)     acc_b <= acc_b + bus_b.pixel_in * bus_b.kernel_in;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit sel_b);
    @(posedge clk); #1;
    if (sel_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // Hand-computed sums: pos0 = 1*2+2*3+3*4+4*5 = 40, pos1 = 5*2+6*3+7*4+8*5 = 96.
  task automatic expectRunA();
    longint sums [2];
    sums[0] = 40;
    sums[1] = 96;
    for (int p = 0; p < PA; p++) begin
      for (int c = 0; c < CA; c++) exp_rd_a.push_back('{addr: p * CA + c, ch: c});
      exp_res_a.push_back('{sum: sums[p], last: (p == PA - 1)});
    end
  endtask

  // Single channel: pixels 1,2,3 times kernel 2.
  task automatic expectRunB();
    longint sums [3];
    sums[0] = 2;
    sums[1] = 4;
    sums[2] = 6;
    for (int p = 0; p < PB; p++) begin
      exp_rd_b.push_back('{addr: p, ch: 0});
      exp_res_b.push_back('{sum: sums[p], last: (p == PB - 1)});
    end
  endtask

  task automatic waitDone(input bit sel_b, input int target, input string tag);
    int n = 0;
    while (((sel_b ? done_b : done_a) < target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, sel_b ? done_b : done_a, target);
  endtask

  // Monitor for instance A: reads, stop runs, idle operands, mac_rst width, results, done.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend_done_a) begin
        checkOutput("done_pulse_a", bus_a.done, 1);
        pend_done_a = 0;
      end else begin
        checkOutput("done_quiet_a", bus_a.done, 0);
      end
      if (bus_a.done) done_a++;
      if (bus_a.pix_rd_en) begin
        if (exp_rd_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL read_a unexpected addr=%0d expected no read", bus_a.pix_addr);
        end else begin
          e_a = exp_rd_a.pop_front();
          checkOutput("pix_addr_a", bus_a.pix_addr, e_a.addr);
          checkOutput("ker_addr_a", bus_a.ker_addr, e_a.ch);
          checkOutput("ker_rd_en_a", bus_a.ker_rd_en, 1);
        end
      end
      if (!bus_a.stop) begin
        run_a++;
      end else begin
        if (run_a != 0) checkOutput("stop_run_a", run_a, CA);
        run_a = 0;
        checkOutput("idle_operands_a", {bus_a.pixel_in, bus_a.kernel_in}, 0);
      end
      if (bus_a.mac_rst) checkOutput("mac_rst_width_a", prev_mrst_a, 0);
      prev_mrst_a = bus_a.mac_rst;
      if (bus_a.result_valid && bus_a.result_ready) begin
        if (exp_res_a.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL result_a unexpected sum=%0d expected no result", acc_a);
        end else begin
          r_a = exp_res_a.pop_front();
          checkOutput("mac_sum_a", acc_a, r_a.sum);
          checkOutput("result_stop_a", bus_a.stop, 1);
          pend_done_a = r_a.last;
        end
      end
    end
  end

  // Monitor for instance B (single channel).
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_b.done) done_b++;
      if (bus_b.pix_rd_en) begin
        if (exp_rd_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL read_b unexpected addr=%0d expected no read", bus_b.pix_addr);
        end else begin
          e_b = exp_rd_b.pop_front();
          checkOutput("pix_addr_b", bus_b.pix_addr, e_b.addr);
          checkOutput("ker_addr_b", bus_b.ker_addr, e_b.ch);
        end
      end
      if (!bus_b.stop) begin
        run_b++;
      end else begin
        if (run_b != 0) checkOutput("stop_run_b", run_b, CB);
        run_b = 0;
      end
      if (bus_b.result_valid && bus_b.result_ready) begin
        if (exp_res_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL result_b unexpected sum=%0d expected no result", acc_b);
        end else begin
          r_b = exp_res_b.pop_front();
          checkOutput("mac_sum_b", acc_b, r_b.sum);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus_a.start        = 1'b0;
    bus_b.start        = 1'b0;
    bus_a.result_ready = 1'b1;
    bus_b.result_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_stop", bus_a.stop, 1);
    checkOutput("rst_mac_rst", bus_a.mac_rst, 0);
    checkOutput("rst_busy", bus_a.busy, 0);
    checkOutput("rst_rd_en", {bus_a.pix_rd_en, bus_a.ker_rd_en}, 0);
    checkOutput("rst_result_valid", bus_a.result_valid, 0);
    checkOutput("rst_stop_b", bus_b.stop, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic runs, ready tied high");
    expectRunA();
    expectRunB();
    fork
      applyStimulus(1'b0);
      applyStimulus(1'b1);
    join
    checkOutput("busy_after_start", bus_a.busy, 1);
    waitDone(1'b0, 1, "done_count_run1_a");
    waitDone(1'b1, 1, "done_count_run1_b");
    checkOutput("rd_queue_empty_b", exp_rd_b.size(), 0);
    checkOutput("res_queue_empty_b", exp_res_b.size(), 0);

    $display("[TB] backpressure on result_ready");
    bus_a.result_ready = 1'b0;
    expectRunA();
    applyStimulus(1'b0);
    n = 0;
    while (!bus_a.result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_result_valid_seen", bus_a.result_valid, 1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_result_valid", bus_a.result_valid, 1);
      checkOutput("bp_stop", bus_a.stop, 1);
      checkOutput("bp_no_read", bus_a.pix_rd_en, 0);
      checkOutput("bp_no_mac_rst", bus_a.mac_rst, 0);
    end
    @(posedge clk); #1;
    bus_a.result_ready = 1'b1;
    waitDone(1'b0, 2, "done_count_bp");

    $display("[TB] reset during FEED");
    expectRunA();
    applyStimulus(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_a.pix_rd_en && bus_a.ker_addr == 2) && n < 100);
    checkOutput("abort_reached_ch2", bus_a.ker_addr, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rd_a.delete();
    exp_res_a.delete();
    run_a       = 0;
    pend_done_a = 0;
    prev_mrst_a = 0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", bus_a.busy, 0);
    checkOutput("abort_stop", bus_a.stop, 1);
    checkOutput("abort_rd_en", bus_a.pix_rd_en, 0);
    checkOutput("abort_result_valid", bus_a.result_valid, 0);
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_a, 2);
    expectRunA();
    applyStimulus(1'b0);
    waitDone(1'b0, 3, "done_count_restart");

    $display("[TB] start while busy and coincident with done");
    expectRunA();
    applyStimulus(1'b0);
    repeat (3) @(posedge clk);
    #1 bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.done && n < 100);
    checkOutput("done_seen_for_coincident", bus_a.done, 1);
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("ignored_start_busy", bus_a.busy, 0);
    checkOutput("ignored_start_done_count", done_a, 4);
    checkOutput("rd_queue_empty_a", exp_rd_a.size(), 0);
    checkOutput("res_queue_empty_a", exp_res_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
